// File: rtl/piso.sv
// Word-to-beat serializer, LSB element first; first beat valid one cycle after accept.
// Holds beat outputs stable while yumi_i is low; a one-word holding buffer gives gapless streaming.
module piso #(
   parameter int width_p = 1,
   parameter int depth_p = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [width_p*depth_p-1:0] data_i,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
   output logic                       last_o,
   input  logic                       yumi_i
);

   localparam int cnt_w = $clog2(depth_p);

   logic [width_p*depth_p-1:0] shift_r;
   logic [width_p*depth_p-1:0] hold_r;
   logic                       act_r;
   logic                       hold_v_r;
   logic [cnt_w-1:0]           cnt_r;

   logic accept;
   logic consume;
   logic free;

   assign data_o  = shift_r[width_p-1:0];
   assign valid_o = act_r;
   assign last_o  = act_r & (cnt_r == cnt_w'(depth_p - 1));
   assign ready_o = ~hold_v_r & ~reset_i;

   assign accept  = valid_i & ready_o;
   assign consume = yumi_i & act_r;
   // Shifter can take a new word on this edge: idle, or its last beat leaves now.
   assign free    = ~act_r | (yumi_i & last_o);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         shift_r  <= '0;
         hold_r   <= '0;
         act_r    <= 1'b0;
         hold_v_r <= 1'b0;
         cnt_r    <= '0;
      end else begin
         if (free && hold_v_r) begin
            shift_r  <= hold_r;
            act_r    <= 1'b1;
            cnt_r    <= '0;
            hold_v_r <= 1'b0;
         end else if (free && accept) begin
            shift_r <= data_i;
            act_r   <= 1'b1;
            cnt_r   <= '0;
         end else begin
            if (consume) begin
               shift_r <= shift_r >> width_p;
               if (last_o) begin
                  act_r <= 1'b0;
                  cnt_r <= '0;
               end else begin
                  cnt_r <= cnt_r + cnt_w'(1);
               end
            end
            if (accept) begin
               hold_r   <= data_i;
               hold_v_r <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_piso.sv
// Directed bench for piso: narrow (1x8) instance driven through a small occupancy model,
// plus a wide (8x4) instance checked against hand-written beats.
module tb_piso;

   logic        clk;
   logic        rst;

   logic        valid_i;
   logic        ready_o;
   logic [7:0]  data_i;
   logic        valid_o;
   logic [0:0]  data_o;
   logic        last_o;
   logic        yumi_i;

   logic        w_valid_i;
   logic        w_ready_o;
   logic [31:0] w_data_i;
   logic        w_valid_o;
   logic [7:0]  w_data_o;
   logic        w_last_o;
   logic        w_yumi_i;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] wq [0:2];
   logic [7:0] wb [0:3];

   piso #(.width_p(1), .depth_p(8)) u_n (
      .clk_i(clk), .reset_i(rst),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .valid_o(valid_o), .data_o(data_o), .last_o(last_o), .yumi_i(yumi_i)
   );

   piso #(.width_p(8), .depth_p(4)) u_w (
      .clk_i(clk), .reset_i(rst),
      .valid_i(w_valid_i), .ready_o(w_ready_o), .data_i(w_data_i),
      .valid_o(w_valid_o), .data_o(w_data_o), .last_o(w_last_o), .yumi_i(w_yumi_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Streams wq[0..nw-1]; mode 0 = yumi always 1, mode 1 = yumi alternating 1,0.
   // Model: occ words in flight, beat = index into the concatenated beat stream.
   task automatic run_stream(input int nw, input int mode, input int ncyc);
      int   occ;
      int   beat;
      int   sent;
      logic exp_v;
      logic acc;
      logic done;
      occ  = 0;
      beat = 0;
      sent = 0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         exp_v = (occ > 0);
         chk("ready", {31'd0, ready_o}, {31'd0, occ < 2});
         chk("valid", {31'd0, valid_o}, {31'd0, exp_v});
         if (exp_v) begin
            chk("data", {31'd0, data_o}, {31'd0, wq[beat/8][beat%8]});
            chk("last", {31'd0, last_o}, {31'd0, (beat % 8) == 7});
         end
         yumi_i  = (mode == 0) ? 1'b1 : ((c % 2) == 0);
         valid_i = (sent < nw);
         data_i  = wq[(sent < nw) ? sent : 0];
         acc  = valid_i && (occ < 2);
         done = exp_v && yumi_i && ((beat % 8) == 7);
         if (exp_v && yumi_i) beat++;
         occ  = occ + (acc ? 1 : 0) - (done ? 1 : 0);
         if (acc) sent++;
      end
      valid_i = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      valid_i   = 1'b0;
      data_i    = '0;
      yumi_i    = 1'b0;
      w_valid_i = 1'b0;
      w_data_i  = '0;
      w_yumi_i  = 1'b0;
      wb[0] = 8'hAA; wb[1] = 8'hBB; wb[2] = 8'hCC; wb[3] = 8'hDD;

      // Reset state
      #1;
      chk("rst_valid", {31'd0, valid_o}, 32'd0);
      chk("rst_last",  {31'd0, last_o},  32'd0);
      chk("rst_data",  {31'd0, data_o},  32'd0);
      chk("rst_ready", {31'd0, ready_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready", {31'd0, ready_o}, 32'd1);

      // Single word, free-running consumer
      wq[0] = 8'h85;
      run_stream(1, 0, 11);

      // Back-to-back words
      wq[0] = 8'h85; wq[1] = 8'hBA; wq[2] = 8'h16;
      run_stream(3, 0, 30);

      // Backpressure
      wq[0] = 8'h85;
      run_stream(1, 1, 20);

      // Spurious yumi while idle
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_valid", {31'd0, valid_o}, 32'd0);
         chk("idle_data",  {31'd0, data_o},  32'd0);
         chk("idle_ready", {31'd0, ready_o}, 32'd1);
         yumi_i = 1'b1;
      end
      wq[0] = 8'h0F;
      run_stream(1, 0, 11);

      // Reset mid-word with a word held
      wq[0] = 8'h85; wq[1] = 8'hBA;
      run_stream(2, 0, 4);
      @(negedge clk);
      chk("pre_rst_hold", {31'd0, ready_o}, 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
      chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      yumi_i = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, ready_o}, 32'd1);
      chk("post_rst_valid", {31'd0, valid_o}, 32'd0);
      wq[0] = 8'h0F;
      run_stream(1, 0, 11);

      // Wide beats
      @(negedge clk);
      w_valid_i = 1'b1;
      w_data_i  = 32'hDDCCBBAA;
      w_yumi_i  = 1'b1;
      @(negedge clk);
      w_valid_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("w_valid", {31'd0, w_valid_o}, 32'd1);
         chk("w_data",  {24'd0, w_data_o},  {24'd0, wb[k]});
         chk("w_last",  {31'd0, w_last_o},  {31'd0, k == 3});
         @(negedge clk);
      end
      chk("w_end_valid", {31'd0, w_valid_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
